qam_symbol_sched: RTL and testbench



---
 rtl/qam_symbol_sched.sv | 138 +++++++++++++
 tb/tb_qam_symbol_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/qam_symbol_sched.sv
// rtl/qam_symbol_sched.sv - 4-QAM frame scheduler: PREAMBLE/PAYLOAD/GAP sequencing,
// carrier phase counter and upstream symbol handshake.
module qam_symbol_sched #(
  parameter int SPS     = 128,
  parameter int PRE_LEN = 8,
  parameter int PAY_LEN = 32,
  parameter int GAP_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [6:0] phase_addr,
  output logic [1:0] sym_out,
  output logic       carrier_on,
  output logic       sym_start,
  output logic       frame_start,
  output logic       busy,
  output logic [7:0] underrun_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [6:0]  PH_LAST  = 7'(SPS - 1);
  localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 1);
  localparam logic [15:0] PAY_LAST = 16'(PAY_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [15:0] idx;
  logic [15:0] idx_nx;
  logic        boundary;
  logic        last_idx;

  assign boundary = (state != S_IDLE) && (phase_addr == PH_LAST);
  assign busy     = (state != S_IDLE);

  always_comb begin
    last_idx = 1'b0;
    case (state)
      S_PRE:   last_idx = (idx == PRE_LAST);
      S_PAY:   last_idx = (idx == PAY_LAST);
      S_GAP:   last_idx = (idx == GAP_LAST);
      default: last_idx = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (boundary) begin
      if (last_idx) begin
        idx_nx = 16'd0;
        case (state)
          S_PRE:   state_nx = S_PAY;
          S_PAY:   state_nx = S_GAP;
          S_GAP:   state_nx = enable ? S_PRE : S_IDLE;
          default: state_nx = S_IDLE;
        endcase
      end else begin
        idx_nx = idx + 16'd1;
      end
    end
  end

  // Ready only on the boundary that opens a payload symbol; never looks at sym_valid.
  assign sym_ready = !reset && boundary && (state_nx == S_PAY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= 16'd0;
      phase_addr   <= 7'd0;
      sym_out      <= 2'b00;
      carrier_on   <= 1'b0;
      sym_start    <= 1'b0;
      frame_start  <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      sym_start   <= 1'b0;
      frame_start <= 1'b0;
      state       <= state_nx;
      idx         <= idx_nx;
      if (state == S_IDLE) begin
        phase_addr <= 7'd0;
        carrier_on <= 1'b0;
        sym_out    <= 2'b00;
        if (enable) begin
          state       <= S_PRE;
          idx         <= 16'd0;
          sym_start   <= 1'b1;
          frame_start <= 1'b1;
          carrier_on  <= 1'b1;
        end
      end else begin
        phase_addr <= boundary ? 7'd0 : phase_addr + 7'd1;
        if (boundary) begin
          case (state_nx)
            S_PRE: begin
              sym_start   <= 1'b1;
              frame_start <= (state == S_GAP);
              sym_out     <= {idx_nx[0], idx_nx[0]};
              carrier_on  <= 1'b1;
            end
            S_PAY: begin
              sym_start <= 1'b1;
              if (sym_valid) begin
                sym_out    <= sym_in;
                carrier_on <= 1'b1;
              end else begin
                // Missed slot is transmitted as silence; the frame keeps its length.
                sym_out    <= 2'b00;
                carrier_on <= 1'b0;
                if (underrun_cnt != 8'hff) underrun_cnt <= underrun_cnt + 8'd1;
              end
            end
            S_GAP: begin
              sym_start  <= 1'b1;
              sym_out    <= 2'b00;
              carrier_on <= 1'b0;
            end
            default: begin
              sym_out    <= 2'b00;
              carrier_on <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_sched.sv
// tb/tb_qam_symbol_sched.sv - directed bench: small-frame config plus default config.
module tb_qam_symbol_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enable;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic [6:0] phase_addr;
  logic [1:0] sym_out;
  logic       carrier_on;
  logic       sym_start;
  logic       frame_start;
  logic       busy;
  logic [7:0] underrun_cnt;

  logic       enable2;
  logic [1:0] sym_in2;
  logic       sym_valid2;
  logic       sym_ready2;
  logic [6:0] phase2;
  logic [1:0] sym_out2;
  logic       carrier2;
  logic       sym_start2;
  logic       frame_start2;
  logic       busy2;
  logic [7:0] underrun2;

  qam_symbol_sched #(.SPS(4), .PRE_LEN(2), .PAY_LEN(4), .GAP_LEN(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .phase_addr(phase_addr), .sym_out(sym_out),
    .carrier_on(carrier_on), .sym_start(sym_start), .frame_start(frame_start),
    .busy(busy), .underrun_cnt(underrun_cnt)
  );

  qam_symbol_sched dut_def (
    .clk(clk), .reset(reset), .enable(enable2), .sym_in(sym_in2), .sym_valid(sym_valid2),
    .sym_ready(sym_ready2), .phase_addr(phase2), .sym_out(sym_out2),
    .carrier_on(carrier2), .sym_start(sym_start2), .frame_start(frame_start2),
    .busy(busy2), .underrun_cnt(underrun2)
  );

  int total = 0;
  int bad   = 0;
  logic [1:0] data [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one sample after the enabling edge; walks the 32-cycle small frame.
  task automatic run_frame(input string tag, input logic [3:0] drop,
                           input logic [15:0] esym, input logic [7:0] ecar);
    int np;
    int ptr;
    logic xfer;
    np  = 0;
    ptr = 0;
    sym_in = data[0];
    for (int t = 0; t < 32; t++) begin
      sym_valid = drop[np[1:0]] ? 1'b0 : 1'b1;
      chk({tag, "_phase"}, phase_addr, t % 4);
      chk({tag, "_sym_start"}, sym_start, (t % 4 == 0));
      chk({tag, "_frame_start"}, frame_start, (t == 0));
      chk({tag, "_busy"}, busy, 1);
      if (t % 4 == 0) begin
        chk({tag, "_sym_out"}, sym_out, esym[2*(t/4) +: 2]);
        chk({tag, "_carrier"}, carrier_on, ecar[t/4]);
      end
      if (sym_ready) begin
        chk({tag, "_ready_phase"}, phase_addr, 3);
        np++;
      end
      xfer = sym_ready && sym_valid;
      step();
      if (xfer) ptr++;
      sym_in = data[ptr[1:0]];
    end
    chk({tag, "_ready_pulses"}, np, 4);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_phase"}, phase_addr, 0);
    chk({tag, "_end_carrier"}, carrier_on, 0);
  endtask

  initial begin
    int n;
    int exp_u;
    logic [6:0] prev;
    reset = 1'b1; enable = 1'b0; sym_in = 2'b00; sym_valid = 1'b1;
    enable2 = 1'b0; sym_in2 = 2'b00; sym_valid2 = 1'b0;
    step(); step(); step();
    chk("rst_ready", sym_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_phase", phase_addr, 0);
    chk("rst_underrun", underrun_cnt, 0);
    reset = 1'b0;
    step(); step();
    chk("idle_phase", phase_addr, 0);
    chk("idle_busy", busy, 0);
    chk("idle_carrier", carrier_on, 0);

    // Single frame: 00,11,01,10,11,00,00,00
    enable = 1'b1; step(); enable = 1'b0;
    run_frame("frame", 4'b0000, 16'h039C, 8'b0011_1111);
    chk("frame_underrun", underrun_cnt, 0);

    // Underrun on the 2nd payload slot; held datum moves to slot 3
    step();
    enable = 1'b1; step(); enable = 1'b0;
    run_frame("under", 4'b0010, 16'h0E1C, 8'b0011_0111);
    chk("under_cnt", underrun_cnt, 1);

    // Back-to-back frames, then enable dropped in payload of the third
    sym_valid = 1'b1;
    enable = 1'b1; step();
    for (int t = 0; t < 96; t++) begin
      if (t == 76) enable = 1'b0;
      chk("b2b_phase", phase_addr, t % 4);
      chk("b2b_frame_start", frame_start, (t % 32 == 0));
      chk("b2b_busy", busy, 1);
      if (t == 88 || t == 92) chk("drop_gap_carrier", carrier_on, 0);
      step();
    end
    chk("drop_idle_busy", busy, 0);
    chk("drop_idle_frame_start", frame_start, 0);
    chk("drop_idle_phase", phase_addr, 0);

    // Reset in payload at the ready boundary
    enable = 1'b1; step(); enable = 1'b0;
    for (int t = 0; t < 11; t++) step();
    chk("pre_rst_ready", sym_ready, 1);
    reset = 1'b1; #1;
    chk("rst_hi_ready", sym_ready, 0);
    step();
    chk("mid_rst_phase", phase_addr, 0);
    chk("mid_rst_sym_out", sym_out, 0);
    chk("mid_rst_carrier", carrier_on, 0);
    chk("mid_rst_sym_start", sym_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_underrun", underrun_cnt, 0);
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    chk("post_rst_phase", phase_addr, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_frame_start", frame_start, 0);

    // Default configuration: back-to-back frames, every payload slot underruns
    enable2 = 1'b1; step();
    chk("def_frame_start0", frame_start2, 1);
    for (int f = 1; f <= 10; f++) begin
      n = 0;
      do begin
        prev = phase2;
        step();
        n++;
        if (f == 1 && prev == 7'd127) chk("def_wrap", phase2, 0);
      end while (!frame_start2 && n < 8000);
      chk("def_frame_len", n, 7168);
      exp_u = (32 * f > 255) ? 255 : 32 * f;
      chk("def_underrun", underrun2, exp_u);
    end
    enable2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
